// File: rtl/a78_pkg.sv
// Shared state encoding and A78 header layout constants for the cartridge loader.
package a78_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArmWait,
    StProbe,
    StHeader,
    StReplay,
    StData,
    StFinish
  } a78_state_e;

  localparam logic [39:0] HDR_MAGIC  = "ATARI";
  localparam int unsigned OFS_FLAGS  = 53;
  localparam int unsigned OFS_JOY0   = 55;
  localparam int unsigned OFS_JOY1   = 56;
  localparam int unsigned OFS_REGION = 57;
  localparam int unsigned OFS_SAVE   = 58;

endpackage

// File: rtl/a78_header_regs.sv
// Offset-decoded capture of the A78 header fields; cleared at the start of each cart download.
module a78_header_regs
  import a78_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        wr_i,
  input  logic [7:0]  addr_i,
  input  logic [7:0]  data_i,
  output logic [15:0] flags_o,
  output logic [7:0]  joy0_o,
  output logic [7:0]  joy1_o,
  output logic [7:0]  region_o,
  output logic [7:0]  save_o
);

  logic [15:0] flags_q, flags_d;
  logic [7:0]  joy0_q, joy0_d, joy1_q, joy1_d, region_q, region_d, save_q, save_d;

  always_comb begin
    flags_d  = flags_q;
    joy0_d   = joy0_q;
    joy1_d   = joy1_q;
    region_d = region_q;
    save_d   = save_q;
    if (clear_i) begin
      flags_d  = '0;
      joy0_d   = '0;
      joy1_d   = '0;
      region_d = '0;
      save_d   = '0;
    end else if (wr_i) begin
      // Offsets 49..52 carry nothing this loader consumes.
      case (addr_i)
        8'(OFS_FLAGS):     flags_d[15:8] = data_i;
        8'(OFS_FLAGS + 1): flags_d[7:0]  = data_i;
        8'(OFS_JOY0):      joy0_d        = data_i;
        8'(OFS_JOY1):      joy1_d        = data_i;
        8'(OFS_REGION):    region_d      = data_i;
        8'(OFS_SAVE):      save_d        = data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      joy0_q   <= '0;
      joy1_q   <= '0;
      region_q <= '0;
      save_q   <= '0;
    end else begin
      flags_q  <= flags_d;
      joy0_q   <= joy0_d;
      joy1_q   <= joy1_d;
      region_q <= region_d;
      save_q   <= save_d;
    end
  end

  assign flags_o  = flags_q;
  assign joy0_o   = joy0_q;
  assign joy1_o   = joy1_q;
  assign region_o = region_q;
  assign save_o   = save_q;

endmodule

// File: rtl/a78_cart_loader.sv
// Converts the ioctl download stream into cart dpram writes, stripping an A78 header when present
// and replaying the probe window for headerless files.
module a78_cart_loader
  import a78_pkg::*;
#(
  parameter int unsigned CART_AW   = 18,
  parameter int unsigned HDR_LEN   = 128,
  parameter int unsigned PROBE_LEN = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ioctl_download,
  input  logic [7:0]         ioctl_index,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               ioctl_wr,
  output logic               cart_wr,
  output logic [CART_AW-1:0] cart_wr_addr,
  output logic [7:0]         cart_wr_data,
  output logic               cart_is_7800,
  output logic [31:0]        cart_size,
  output logic [15:0]        cart_flags,
  output logic [7:0]         joy0_type,
  output logic [7:0]         joy1_type,
  output logic [7:0]         cart_region,
  output logic [7:0]         cart_save,
  output logic               overflow,
  output logic               load_busy,
  output logic               load_done
);

  localparam int unsigned OfsW = 26;

  a78_state_e         state_q, state_d;
  logic               dl_q;
  logic [7:0]         probe_buf_q [PROBE_LEN];
  logic [7:0]         probe_buf_d [PROBE_LEN];
  logic [2:0]         replay_len_q, replay_len_d, replay_idx_q, replay_idx_d;
  logic               pend_valid_q, pend_valid_d;
  logic [24:0]        pend_addr_q, pend_addr_d, last_addr_q, last_addr_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic               seen_q, seen_d, is_7800_q, is_7800_d, overflow_q, overflow_d;
  logic [31:0]        cart_size_q, cart_size_d, size_raw, size_final;
  logic               wr_q, wr_d;
  logic [CART_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic               cart_stb, start;
  logic [24:0]        src_addr;
  logic [7:0]         src_data;
  logic [OfsW-1:0]    ofs;

  assign cart_stb = ioctl_wr & ioctl_download & (ioctl_index != 8'd0);
  assign start    = (state_q == StIdle) & ioctl_download & ~dl_q & (ioctl_index != 8'd0);

  // A byte parked during replay goes through the data path ahead of any live strobe.
  assign src_addr = pend_valid_q ? pend_addr_q : ioctl_addr;
  assign src_data = pend_valid_q ? pend_data_q : ioctl_dout;
  assign ofs      = {1'b0, src_addr} - (is_7800_q ? OfsW'(HDR_LEN) : '0);
  assign size_raw = 32'(last_addr_q) + 32'd1;

  always_comb begin
    size_final = '0;
    if (seen_q) begin
      if (!is_7800_q) size_final = size_raw;
      else if (size_raw >= 32'(HDR_LEN)) size_final = size_raw - 32'(HDR_LEN);
    end
  end

  always_comb begin
    state_d      = state_q;
    probe_buf_d  = probe_buf_q;
    replay_len_d = replay_len_q;
    replay_idx_d = replay_idx_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    last_addr_d  = last_addr_q;
    seen_d       = seen_q;
    is_7800_d    = is_7800_q;
    overflow_d   = overflow_q;
    cart_size_d  = cart_size_q;
    wr_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    if (cart_stb && state_q inside {StProbe, StHeader, StReplay, StData}) begin
      seen_d = 1'b1;
      if (!seen_q || ioctl_addr > last_addr_q) last_addr_d = ioctl_addr;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          probe_buf_d  = '{default: '0};
          replay_len_d = '0;
          replay_idx_d = '0;
          pend_valid_d = 1'b0;
          last_addr_d  = '0;
          seen_d       = 1'b0;
          is_7800_d    = 1'b0;
          overflow_d   = 1'b0;
          cart_size_d  = '0;
          state_d      = StProbe;
        end else if (ioctl_download && dl_q) begin
          state_d = StArmWait;
        end
      end
      StArmWait: if (!ioctl_download) state_d = StIdle;
      StProbe: begin
        if (cart_stb) begin
          if (ioctl_addr < 25'(PROBE_LEN)) begin
            probe_buf_d[ioctl_addr[2:0]] = ioctl_dout;
            if (ioctl_addr[2:0] >= replay_len_q) replay_len_d = ioctl_addr[2:0] + 3'd1;
          end
          if (ioctl_addr == 25'(PROBE_LEN - 1)) begin
            if ({probe_buf_q[1], probe_buf_q[2], probe_buf_q[3], probe_buf_q[4], ioctl_dout}
                == HDR_MAGIC) begin
              is_7800_d = 1'b1;
              state_d   = StHeader;
            end else begin
              state_d = StReplay;
            end
          end
        end else if (!ioctl_download) begin
          state_d = StReplay;
        end
      end
      StHeader: begin
        if (cart_stb && ioctl_addr == 25'(HDR_LEN - 1)) state_d = StData;
        else if (!ioctl_download) state_d = StFinish;
      end
      StReplay: begin
        if (replay_idx_q < replay_len_q) begin
          wr_d      = 1'b1;
          wr_addr_d = CART_AW'(replay_idx_q);
          wr_data_d = probe_buf_q[replay_idx_q];
        end
        replay_idx_d = replay_idx_q + 3'd1;
        if (replay_idx_q + 3'd1 >= replay_len_q) state_d = StData;
        if (cart_stb) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = ioctl_addr;
          pend_data_d  = ioctl_dout;
        end
      end
      StData: begin
        if (pend_valid_q || cart_stb) begin
          pend_valid_d = 1'b0;
          if (ofs[OfsW-1:CART_AW] != '0) begin
            overflow_d = 1'b1;
          end else begin
            wr_d      = 1'b1;
            wr_addr_d = ofs[CART_AW-1:0];
            wr_data_d = src_data;
          end
        end else if (!ioctl_download) begin
          cart_size_d = size_final;
          state_d     = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      dl_q         <= 1'b1;  // a download already active at reset release is not a rising edge
      probe_buf_q  <= '{default: '0};
      replay_len_q <= '0;
      replay_idx_q <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      last_addr_q  <= '0;
      seen_q       <= 1'b0;
      is_7800_q    <= 1'b0;
      overflow_q   <= 1'b0;
      cart_size_q  <= '0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      probe_buf_q  <= probe_buf_d;
      replay_len_q <= replay_len_d;
      replay_idx_q <= replay_idx_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      last_addr_q  <= last_addr_d;
      seen_q       <= seen_d;
      is_7800_q    <= is_7800_d;
      overflow_q   <= overflow_d;
      cart_size_q  <= cart_size_d;
      wr_q         <= wr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  a78_header_regs u_header_regs (
    .clk_i    (clk_sys),
    .rst_ni   (reset_n),
    .clear_i  (start),
    .wr_i     (cart_stb && (state_q == StHeader)),
    .addr_i   (ioctl_addr[7:0]),
    .data_i   (ioctl_dout),
    .flags_o  (cart_flags),
    .joy0_o   (joy0_type),
    .joy1_o   (joy1_type),
    .region_o (cart_region),
    .save_o   (cart_save)
  );

  assign cart_wr      = wr_q;
  assign cart_wr_addr = wr_addr_q;
  assign cart_wr_data = wr_data_q;
  assign cart_is_7800 = is_7800_q;
  assign cart_size    = cart_size_q;
  assign overflow     = overflow_q;
  assign load_busy    = (state_q != StIdle) && (state_q != StArmWait);
  assign load_done    = (state_q == StFinish);

endmodule

// File: tb/tb_a78_cart_loader.sv
// Directed bench for a78_cart_loader: expected dpram writes are queued as files are streamed in.
module tb_a78_cart_loader;

  localparam int unsigned CartAw = 18;
  localparam int unsigned HdrLen = 128;

  typedef struct packed {
    logic [CartAw-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wr;
  logic              cart_wr;
  logic [CartAw-1:0] cart_wr_addr;
  logic [7:0]        cart_wr_data;
  logic              cart_is_7800;
  logic [31:0]       cart_size;
  logic [15:0]       cart_flags;
  logic [7:0]        joy0_type, joy1_type, cart_region, cart_save;
  logic              overflow, load_busy, load_done;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_assert = 0;
  int  n_fail   = 0;
  int  wr_cnt   = 0;
  int  done_cnt = 0;

  a78_cart_loader #(
    .CART_AW   (CartAw),
    .HDR_LEN   (HdrLen),
    .PROBE_LEN (6)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wr       (ioctl_wr),
    .cart_wr        (cart_wr),
    .cart_wr_addr   (cart_wr_addr),
    .cart_wr_data   (cart_wr_data),
    .cart_is_7800   (cart_is_7800),
    .cart_size      (cart_size),
    .cart_flags     (cart_flags),
    .joy0_type      (joy0_type),
    .joy1_type      (joy1_type),
    .cart_region    (cart_region),
    .cart_save      (cart_save),
    .overflow       (overflow),
    .load_busy      (load_busy),
    .load_done      (load_done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) ^ (a >> 8));
  endfunction

  function automatic logic [7:0] hdr_byte(input int a);
    case (a)
      0:              return 8'h01;
      1:              return 8'h41;
      2:              return 8'h54;
      3:              return 8'h41;
      4:              return 8'h52;
      5:              return 8'h49;
      49, 50, 51, 52: return 8'hA5;
      53:             return 8'h00;
      54:             return 8'h02;
      55:             return 8'h01;
      56:             return 8'h02;
      57:             return 8'h01;
      58:             return 8'h03;
      default:        return 8'(a) ^ 8'h5C;
    endcase
  endfunction

  task automatic strobe(input int a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (6) @(negedge clk_sys);
  endtask

  task automatic dl_start(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic dl_end(input string tag, input int exp_done);
    int d0;
    d0 = done_cnt;
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(negedge clk_sys);
    repeat (4) @(negedge clk_sys);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every dpram write must match the oldest queued expectation.
  always @(negedge clk_sys) begin
    if (load_done) done_cnt++;
    if (cart_wr) begin
      wr_cnt++;
      check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(cart_wr_addr), 32'(mon_e.addr));
        check("wr_data", 32'(cart_wr_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         w0;
    int         big;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_wr       = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_cart_wr", 32'(cart_wr), 32'd0);
    check("rst_is_7800", 32'(cart_is_7800), 32'd0);
    check("rst_size", cart_size, 32'd0);
    check("rst_flags", 32'(cart_flags), 32'd0);
    check("rst_busy", 32'(load_busy), 32'd0);
    check("rst_done", 32'(load_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // A78 file: 128-byte header plus 1 KiB ROM.
    w0 = wr_cnt;
    dl_start(8'd1);
    for (int a = 0; a < int'(HdrLen) + 1024; a++) begin
      d = (a < int'(HdrLen)) ? hdr_byte(a) : pat(a);
      if (a >= int'(HdrLen)) exp_q.push_back('{addr: CartAw'(a - int'(HdrLen)), data: d});
      strobe(a, d);
      if (a == 600) check("t1_busy", 32'(load_busy), 32'd1);
    end
    dl_end("t1", 1);
    check("t1_is_7800", 32'(cart_is_7800), 32'd1);
    check("t1_flags", 32'(cart_flags), 32'h0002);
    check("t1_joy0", 32'(joy0_type), 32'h01);
    check("t1_joy1", 32'(joy1_type), 32'h02);
    check("t1_region", 32'(cart_region), 32'h01);
    check("t1_save", 32'(cart_save), 32'h03);
    check("t1_size", cart_size, 32'd1024);
    check("t1_writes", 32'(wr_cnt - w0), 32'd1024);
    check("t1_busy_after", 32'(load_busy), 32'd0);

    // Headerless 2 KiB file: probe window replayed, then straight pass-through.
    w0 = wr_cnt;
    dl_start(8'd1);
    for (int a = 0; a < 2048; a++) begin
      if (a == 5) begin
        for (int k = 0; k < 6; k++) exp_q.push_back('{addr: CartAw'(k), data: pat(k)});
      end else if (a > 5) begin
        exp_q.push_back('{addr: CartAw'(a), data: pat(a)});
      end
      strobe(a, pat(a));
    end
    dl_end("t2", 1);
    check("t2_is_7800", 32'(cart_is_7800), 32'd0);
    check("t2_size", cart_size, 32'd2048);
    check("t2_writes", 32'(wr_cnt - w0), 32'd2048);
    check("t2_flags_cleared", 32'(cart_flags), 32'd0);

    // 3-byte file ends inside the probe window.
    w0 = wr_cnt;
    dl_start(8'd2);
    for (int a = 0; a < 3; a++) strobe(a, pat(a));
    for (int k = 0; k < 3; k++) exp_q.push_back('{addr: CartAw'(k), data: pat(k)});
    dl_end("t3a", 1);
    check("t3a_size", cart_size, 32'd3);
    check("t3a_writes", 32'(wr_cnt - w0), 32'd3);
    check("t3a_is_7800", 32'(cart_is_7800), 32'd0);

    // 100-byte file with the magic ends inside the header.
    w0 = wr_cnt;
    dl_start(8'd1);
    for (int a = 0; a < 100; a++) strobe(a, hdr_byte(a));
    dl_end("t3b", 1);
    check("t3b_size", cart_size, 32'd0);
    check("t3b_writes", 32'(wr_cnt - w0), 32'd0);
    check("t3b_is_7800", 32'(cart_is_7800), 32'd1);
    check("t3b_region", 32'(cart_region), 32'h01);

    // Headerless file whose tail crosses 2**CART_AW: the four top bytes are dropped.
    big = 1 << CartAw;
    w0  = wr_cnt;
    dl_start(8'd1);
    for (int a = 0; a < 6; a++) begin
      if (a == 5) begin
        for (int k = 0; k < 6; k++) exp_q.push_back('{addr: CartAw'(k), data: pat(k)});
      end
      strobe(a, pat(a));
    end
    for (int a = big - 2; a < big + 4; a++) begin
      if (a < big) exp_q.push_back('{addr: CartAw'(a), data: pat(a)});
      strobe(a, pat(a));
    end
    dl_end("t4", 1);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_size", cart_size, 32'(big + 4));
    check("t4_writes", 32'(wr_cnt - w0), 32'd8);

    // BIOS download is ignored entirely.
    w0 = wr_cnt;
    dl_start(8'd0);
    for (int a = 0; a < 10; a++) strobe(a, pat(a));
    check("t6_busy", 32'(load_busy), 32'd0);
    dl_end("t6", 0);
    check("t6_writes", 32'(wr_cnt - w0), 32'd0);
    check("t6_size_kept", cart_size, 32'(big + 4));
    check("t6_overflow_kept", 32'(overflow), 32'd1);

    // Reset in the middle of an A78 load, then a clean reload.
    dl_start(8'd1);
    for (int a = 0; a < 2000; a++) begin
      d = (a < int'(HdrLen)) ? hdr_byte(a) : pat(a);
      if (a >= int'(HdrLen)) exp_q.push_back('{addr: CartAw'(a - int'(HdrLen)), data: d});
      strobe(a, d);
    end
    @(negedge clk_sys);
    ioctl_addr = 25'd2000;
    ioctl_dout = pat(2000);
    ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
    check("t5_wr_live", 32'(cart_wr), 32'd1);
    check("t5_region_live", 32'(cart_region), 32'h01);
    reset_n = 1'b0;
    #1;
    check("t5_rst_wr", 32'(cart_wr), 32'd0);
    check("t5_rst_is_7800", 32'(cart_is_7800), 32'd0);
    check("t5_rst_region", 32'(cart_region), 32'd0);
    check("t5_rst_busy", 32'(load_busy), 32'd0);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    w0 = wr_cnt;
    for (int a = 2001; a < 2021; a++) strobe(a, pat(a));
    check("t5_armwait_busy", 32'(load_busy), 32'd0);
    dl_end("t5_abort", 0);
    check("t5_abort_writes", 32'(wr_cnt - w0), 32'd0);

    w0 = wr_cnt;
    dl_start(8'd1);
    for (int a = 0; a < int'(HdrLen) + 64; a++) begin
      d = (a < int'(HdrLen)) ? hdr_byte(a) : pat(a);
      if (a >= int'(HdrLen)) exp_q.push_back('{addr: CartAw'(a - int'(HdrLen)), data: d});
      strobe(a, d);
    end
    dl_end("t5_reload", 1);
    check("t5_reload_size", cart_size, 32'd64);
    check("t5_reload_is_7800", 32'(cart_is_7800), 32'd1);
    check("t5_reload_writes", 32'(wr_cnt - w0), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
